// File: rtl/mul_share_pkg.sv
// mul_share_pkg -- shared types and helpers for the multiplier-sharing controller.
//   state_t  : controller FSM states (IDLE, WAIT, RESP)
//   A_W, C_W : multiplier operand-a and product widths
//   popcount : set-bit count, used by the optional operand check
package mul_share_pkg;

  localparam int A_W = 16;
  localparam int C_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Callers zero-extend narrower vectors to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_arb.sv
// rr_arbiter -- combinational round-robin arbiter.
// Searches req starting at index ptr and wraps around, granting the first
// active requester. The pointer register is owned by the instantiating block.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  IDW   index the search starts from
//   en      in  1     arbitration enable; no grant when low
//   gnt     out NREQ  one-hot grant (or zero)
//   gnt_idx out IDW   binary index of the granted requester (0 when none)
//   gnt_vld out 1     a grant was made
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  int unsigned j;

  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl -- time-shares one two-bit multiplier among NREQ requesters.
// A round-robin arbiter grants one requester in IDLE and issues its operands
// to the multiplier in the same cycle; all requesters are then held off until
// the product has been returned on the tagged response channel.
// Optional feature: define MUL_SHARE_OPCHECK_EN to reject operands whose b
// has more than two set bits (accepted, not issued, answered with rsp_err=1).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_vld/req_rdy   per-requester valid / one-hot accept (combinational)
//   req_a, req_b      per-requester operands
//   rsp_vld/rsp_rdy   response handshake
//   rsp_id, rsp_c     requester index and product of the response
//   rsp_err           operand check rejected the request (rsp_c = 0)
//   mul_vld, mul_a/b  issue strobe and operands to the multiplier
//   mul_c, mul_result_vld  product and its strobe from the multiplier
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ-1:0][A_W-1:0]  req_a,
  input  logic [NREQ-1:0][N-1:0]    req_b,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [IDW-1:0]            rsp_id,
  output logic [C_W-1:0]            rsp_c,
  output logic                      rsp_err,
  output logic                      mul_vld,
  output logic [A_W-1:0]            mul_a,
  output logic [N-1:0]              mul_b,
  input  logic [C_W-1:0]            mul_c,
  input  logic                      mul_result_vld
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_vld;
  logic [A_W-1:0]   win_a;
  logic [N-1:0]     win_b;
  logic             op_bad;
  logic [IDW-1:0]   next_ptr;

  // Gating with rst_n keeps req_rdy/mul_vld at zero during the reset cycle
  // even if a requester is already presenting.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_vld),
    .ptr     (rr_ptr),
    .en      (rst_n && (state == IDLE)),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign win_a = req_a[gnt_idx];
  assign win_b = req_b[gnt_idx];

`ifdef MUL_SHARE_OPCHECK_EN
  assign op_bad = gnt_vld && (popcount(32'(win_b)) > 2);
`else
  assign op_bad = 1'b0;
`endif

  // A rejected request is still accepted so the requester is released.
  assign req_rdy = gnt;
  assign mul_vld = gnt_vld && !op_bad;
  assign mul_a   = mul_vld ? win_a : '0;
  assign mul_b   = mul_vld ? win_b : '0;

  assign next_ptr = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cur_id  <= '0;
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_c   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            cur_id <= gnt_idx;
            rr_ptr <= next_ptr;
            if (op_bad) begin
              // Skip the multiplier entirely and answer at once.
              state   <= RESP;
              rsp_vld <= 1'b1;
              rsp_id  <= gnt_idx;
              rsp_c   <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mul_result_vld) begin
            state   <= RESP;
            rsp_vld <= 1'b1;
            rsp_id  <= cur_id;
            rsp_c   <= mul_c;
          end
        end
        RESP: begin
          // Response fields hold until accepted; the next grant waits for IDLE.
          if (rsp_rdy) begin
            state   <= IDLE;
            rsp_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUL_SHARE_OPCHECK_EN
  logic rsp_err_q;

  // Updated on every grant: set for a rejected request, cleared for an issued
  // one, so it is already correct when the product arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (gnt_vld) begin
      rsp_err_q <= op_bad;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl -- self-checking bench for mul_share_ctrl.
// Contains a behavioural two-cycle multiplier (result strobe two cycles after
// issue, flushed by the shared reset), a vector table of transactions with
// expected grant and response, and a scoreboard of expected responses.
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  localparam int NREQ = 4;
  localparam int N    = 4;
  localparam int IDW  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NREQ-1:0]          req_vld;
  logic [NREQ-1:0]          req_rdy;
  logic [NREQ-1:0][A_W-1:0] req_a;
  logic [NREQ-1:0][N-1:0]   req_b;
  logic                     rsp_vld;
  logic                     rsp_rdy;
  logic [IDW-1:0]           rsp_id;
  logic [C_W-1:0]           rsp_c;
  logic                     rsp_err;
  logic                     mul_vld;
  logic [A_W-1:0]           mul_a;
  logic [N-1:0]             mul_b;
  logic [C_W-1:0]           mul_c;
  logic                     mul_result_vld;

  mul_share_ctrl #(.NREQ(NREQ), .N(N), .IDW(IDW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_id         (rsp_id),
    .rsp_c          (rsp_c),
    .rsp_err        (rsp_err),
    .mul_vld        (mul_vld),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_c          (mul_c),
    .mul_result_vld (mul_result_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: strobe in T, result in T+2.
  logic        m_v1, m_v2;
  logic [31:0] m_p1, m_p2;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_v1 <= 1'b0;
      m_v2 <= 1'b0;
      m_p1 <= '0;
      m_p2 <= '0;
    end else begin
      m_v1 <= mul_vld;
      m_p1 <= 32'(mul_a) * 32'(mul_b);
      m_v2 <= m_v1;
      m_p2 <= m_p1;
    end
  end
  assign mul_result_vld = m_v2;
  assign mul_c          = m_p2;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [3:0]  b;
    int          exp_id;
    logic [31:0] exp_c;
    logic        exp_err;
    int          hold;     // cycles rsp_rdy stays low once rsp_vld rises
  } vec_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] c;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   prev_hs = -1;

  task automatic run_entry(input vec_t v, input string tag);
    int   t_acc;
    logic found;
    rsp_t e;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = v.a;
      req_b[i] = v.b;
    end
    req_vld = v.mask;
    rsp_rdy = (v.hold == 0);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (|(req_vld & req_rdy)) found = 1'b1;
      else @(posedge clk) #1;
    end
    if (!found) begin
      timeout({tag, " accept"});
      req_vld = '0;
      return;
    end
    t_acc = cyc;
    check({tag, " req_rdy"}, 32'(req_rdy), 32'(1) << v.exp_id);
    check({tag, " mul_vld"}, 32'(mul_vld), 32'(!v.exp_err));
    check({tag, " mul_a"},   32'(mul_a),   v.exp_err ? 32'd0 : 32'(v.a));
    check({tag, " mul_b"},   32'(mul_b),   v.exp_err ? 32'd0 : 32'(v.b));
    check({tag, " rsp_vld idle"}, 32'(rsp_vld), 32'd0);
    if (prev_hs >= 0) check({tag, " grant cycle"}, 32'(t_acc), 32'(prev_hs + 1));
    sb.push_back('{id: v.exp_id[1:0], c: v.exp_c, err: v.exp_err});

    // Winner drops its request; the others keep theirs to probe hold-off.
    @(posedge clk) #1;
    req_vld = v.mask & ~(4'b0001 << v.exp_id);

    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (rsp_vld) found = 1'b1;
      else begin
        check({tag, " busy req_rdy"}, 32'(req_rdy), 32'd0);
        check({tag, " busy mul_vld"}, 32'(mul_vld), 32'd0);
        @(posedge clk) #1;
      end
    end
    if (!found) begin
      timeout({tag, " response"});
      req_vld = '0;
      return;
    end
    check({tag, " rsp latency"}, 32'(cyc - t_acc), v.exp_err ? 32'd1 : 32'd3);
    if (sb.size() == 0) begin
      timeout({tag, " scoreboard empty"});
      return;
    end
    e = sb.pop_front();
    check({tag, " rsp_id"},  32'(rsp_id),  32'(e.id));
    check({tag, " rsp_c"},   rsp_c,        e.c);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));

    if (v.hold > 0) begin
      repeat (v.hold - 1) begin
        @(posedge clk) #1;
        @(negedge clk);
        check({tag, " hold rsp_vld"}, 32'(rsp_vld), 32'd1);
        check({tag, " hold rsp_id"},  32'(rsp_id),  32'(e.id));
        check({tag, " hold rsp_c"},   rsp_c,        e.c);
        check({tag, " hold rsp_err"}, 32'(rsp_err), 32'(e.err));
        check({tag, " hold req_rdy"}, 32'(req_rdy), 32'd0);
        check({tag, " hold mul_vld"}, 32'(mul_vld), 32'd0);
      end
      @(posedge clk) #1;
      rsp_rdy = 1'b1;
      @(negedge clk);
      check({tag, " release rsp_vld"}, 32'(rsp_vld), 32'd1);
    end
    prev_hs = cyc;
    @(posedge clk) #1;
    rsp_rdy = 1'b0;
  endtask

  vec_t tab[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{4'b0001, 16'h0003, 4'b0101, 0, 32'd15,      1'b0, 0};
    tab[1] = '{4'b1111, 16'h0005, 4'b0010, 1, 32'd10,      1'b0, 0};
    tab[2] = '{4'b1111, 16'h0007, 4'b1000, 2, 32'd56,      1'b0, 0};
    tab[3] = '{4'b1111, 16'h1234, 4'b1001, 3, 32'h0000A3D4, 1'b0, 0};
    tab[4] = '{4'b1111, 16'hFFFF, 4'b1100, 0, 32'h000BFFF4, 1'b0, 0};
    tab[5] = '{4'b0001, 16'hFFFF, 4'b0000, 0, 32'd0,       1'b0, 5};
    tab[6] = '{4'b0100, 16'h0002, 4'b0011, 2, 32'd6,       1'b0, 0};
    tab[7] = '{4'b0011, 16'h0009, 4'b0110, 0, 32'd54,      1'b0, 0};
`ifdef MUL_SHARE_OPCHECK_EN
    tab[8] = '{4'b1000, 16'h00FF, 4'b0111, 3, 32'd0,       1'b1, 0};
`else
    tab[8] = '{4'b1000, 16'h00FF, 4'b0111, 3, 32'h000006F9, 1'b0, 0};
`endif
    tab[9] = '{4'b1111, 16'h0101, 4'b0100, 0, 32'h00000404, 1'b0, 0};

    rst_n   = 1'b0;
    req_vld = '0;
    rsp_rdy = 1'b0;
    req_a   = '0;
    req_b   = '0;
    @(posedge clk) #1;
    @(negedge clk);
    check("reset rsp_vld", 32'(rsp_vld), 32'd0);
    check("reset rsp_id",  32'(rsp_id),  32'd0);
    check("reset rsp_c",   rsp_c,        32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset req_rdy", 32'(req_rdy), 32'd0);
    check("reset mul_vld", 32'(mul_vld), 32'd0);
    check("reset mul_a",   32'(mul_a),   32'd0);
    check("reset mul_b",   32'(mul_b),   32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_entry(tab[i], $sformatf("vec%0d", i));
    end

    // Reset while WAITing: request from requester 1 is dropped silently.
    req_a   = {NREQ{16'h0004}};
    req_b   = {NREQ{4'b0001}};
    req_vld = 4'b0010;
    @(negedge clk);
    check("rstwait grant", 32'(req_rdy), 32'h2);
    check("rstwait issue", 32'(mul_vld), 32'd1);
    @(posedge clk) #1;
    req_vld = '0;
    rst_n   = 1'b0;
    @(posedge clk) #1;
    rst_n   = 1'b1;
    @(negedge clk);
    check("rstwait rsp_vld", 32'(rsp_vld), 32'd0);
    check("rstwait rsp_id",  32'(rsp_id),  32'd0);
    check("rstwait rsp_c",   rsp_c,        32'd0);
    check("rstwait rsp_err", 32'(rsp_err), 32'd0);
    check("rstwait mul_vld", 32'(mul_vld), 32'd0);
    repeat (6) begin
      @(posedge clk) #1;
      @(negedge clk);
      check("rstwait no response", 32'(rsp_vld), 32'd0);
    end
    @(posedge clk) #1;
    prev_hs = -1;
    run_entry(tab[9], "after_reset");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Controller that time-shares one two-bit multiplier instance among NREQ requesters. Each requester presents an operand pair on a valid/ready channel. A round-robin arbiter grants one requester and issues the pair to the multiplier. The controller then holds off all requesters until the multiplier result has been returned on a single tagged response channel. The block sits between the requesters and the `two_bit_multiplier2`-style datapath (16-bit `a`, N-bit `b` with at most two set bits, 32-bit product).

## Interface
- NREQ, 4, number of requesters (2..8)
- N, 4, width of operand b; must match the multiplier's N
- IDW, $clog2(NREQ), requester id width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_vld  in  NREQ  per-requester request valid
- req_rdy  out  NREQ  per-requester grant/accept, one-hot or zero
- req_a  in  NREQ×16  operand a per requester
- req_b  in  NREQ×N  operand b per requester
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response accept
- rsp_id  out  IDW  requester index the response belongs to
- rsp_c  out  32  product
- rsp_err  out  1  request rejected (operand check), rsp_c = 0
- mul_vld  out  1  issue strobe to multiplier
- mul_a  out  16  operand a to multiplier
- mul_b  out  N  operand b to multiplier
- mul_c  in  32  multiplier product
- mul_result_vld  in  1  multiplier result strobe

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - The arbiter picks the first requester with req_vld set, searching from rr_ptr upward with wrap.
  - The winner gets req_rdy=1 in the same cycle (combinational). mul_vld=1, and mul_a/mul_b carry the winner's operands.
  - The winner's index is registered as cur_id; rr_ptr becomes cur_id+1 (mod NREQ). The FSM moves to WAIT.
  - If no requester is valid: req_rdy=0, mul_vld=0, the FSM stays in IDLE, and rr_ptr does not change.
- WAIT:
  - req_rdy=0 and mul_vld=0.
  - On mul_result_vld, capture mul_c into rsp_c, set rsp_id=cur_id and rsp_err=0, and go to RESP.
- RESP:
  - rsp_vld=1.
  - When rsp_rdy=1, clear rsp_vld and go to IDLE. No new grant is issued in that same cycle.
  - rsp_id, rsp_c and rsp_err hold stable while rsp_vld=1 && !rsp_rdy.
- mul_vld is asserted only in IDLE. The multiplier therefore never sees a strobe while busy.
- mul_result_vld outside WAIT is ignored.
- mul_a/mul_b are driven 0 when mul_vld=0.
- Reset values:
  - req_rdy=0, rsp_vld=0, rsp_id=0, rsp_c=0, rsp_err=0, mul_vld=0, mul_a=0, mul_b=0.
  - State=IDLE, rr_ptr=0, cur_id=0.
- Reset mid-operation: the controller and the multiplier share rst_n. Any in-flight request is dropped and produces no response. The requester must re-present it.
- A requester must hold req_vld and its operands stable until it sees req_rdy.

## Timing
- Accept cycle T (req_vld & req_rdy): mul_vld is high in T.
- The multiplier asserts mul_result_vld in T+2.
- rsp_vld rises in T+3.
- The earliest next grant is in the cycle after the rsp handshake.
- Throughput with rsp_rdy tied high: one product per 4 cycles.
- Rejected request (with the macro below): rsp_vld rises in T+1, rsp_err=1, rsp_c=0. No multiplier issue occurs.

## Configuration
- MUL_SHARE_OPCHECK_EN defined:
  - In IDLE, if the winner's popcount(req_b) > 2, the request is still accepted (req_rdy=1), but mul_vld stays 0.
  - The FSM goes directly to RESP with rsp_err=1, rsp_c=0 and rsp_id set to the winner's index.
  - rr_ptr advances as usual.
- Undefined: no check is made. Every request is issued, and rsp_err is tied to 0.

## Structure
- Package mul_share_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the A_W=16 and C_W=32 constants;
  - the popcount function used by the operand check.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req vector, rr_ptr, enable;
  - outputs: one-hot grant and the binary grant index.
  - It is purely combinational; the pointer register lives in mul_share_ctrl.

## Test plan
- Single request: req 0, a=3, b=4'b0101 -> mul_vld in T; rsp_vld in T+3 with rsp_id=0, rsp_c=15, rsp_err=0.
- Round-robin: all four req_vld held high, rsp_rdy=1 -> grants in order 0,1,2,3,0, spaced 4 cycles apart.
- Backpressure: rsp_rdy=0 for 5 cycles after rsp_vld rises -> rsp_id, rsp_c and rsp_err stay stable, req_rdy stays 0 and mul_vld stays 0; the next grant comes the cycle after rsp_rdy=1.
- Zero operand: a=0xFFFF, b=0 -> rsp_c=0, rsp_err=0.
- Operand check (macro on): b=4'b0111 -> req_rdy in T, mul_vld never asserted, rsp_vld in T+1 with rsp_err=1 and rsp_c=0. With the macro off, the same request is issued to the multiplier.
- Reset in WAIT: rst_n low for 1 cycle -> all outputs return to reset values and no response is produced; the next request is granted from rr_ptr=0.
